// File: rtl/fib_pkg.sv
// Shared widths and controller state encoding for the Fibonacci request controller.
package fib_pkg;

    localparam int N_W = 4;
    localparam int F_W = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/fib_ctrl_wdog.sv
// WAIT-state watchdog: counts enabled cycles and flags expiry on the TIMEOUT-th one.
// Only compiled when FIB_CTRL_TIMEOUT_EN is defined.
`ifdef FIB_CTRL_TIMEOUT_EN
module fib_ctrl_wdog #(
    parameter int TIMEOUT = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Combinational so the controller leaves WAIT right after the last counted cycle.
    assign expire = en && !clr && (cnt_q == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`endif

// File: rtl/fib_ctrl.sv
// Request/response front end driving a multi-cycle Fibonacci engine (rsp_f = F(n+1)).
// Defining FIB_CTRL_TIMEOUT_EN adds a WAIT watchdog that returns rsp_err=1 on expiry.
module fib_ctrl
    import fib_pkg::*;
#(
    parameter int TIMEOUT = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic [N_W-1:0] req_n,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [F_W-1:0] rsp_f,
    output logic [N_W-1:0] rsp_n,
    output logic           rsp_err,
    input  logic           pause_in,
    output logic           fib_start,
    output logic           fib_pause,
    output logic [N_W-1:0] fib_n,
    input  logic           fib_busy,
    input  logic           fib_done,
    input  logic [F_W-1:0] fib_f,
    output logic [1:0]     state_dbg
);

    // Both handshakes: a transfer happens on a rising clk edge where valid && ready;
    // valid never depends combinationally on ready, and payload holds while valid && !ready.

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("fib_ctrl: TIMEOUT must be at least 1");
    end

    state_t         state_q, state_d;
    logic [N_W-1:0] n_q, n_d;
    logic [F_W-1:0] rsp_f_q, rsp_f_d;
    logic [N_W-1:0] rsp_n_q, rsp_n_d;

`ifdef FIB_CTRL_TIMEOUT_EN
    logic rsp_err_q, rsp_err_d;
    logic wd_clr, wd_en, wd_expire;

    fib_ctrl_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk    (clk),
        .rst    (rst),
        .clr    (wd_clr),
        .en     (wd_en),
        .expire (wd_expire)
    );
`endif

    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        rsp_f_d   = rsp_f_q;
        rsp_n_d   = rsp_n_q;
        req_ready = 1'b0;
        fib_start = 1'b0;
        rsp_valid = 1'b0;
`ifdef FIB_CTRL_TIMEOUT_EN
        rsp_err_d = rsp_err_q;
        wd_clr    = 1'b1;
        wd_en     = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    n_d     = req_n;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // The engine has no reset, so a start must wait out any leftover run.
                fib_start = !fib_busy;
                if (!fib_busy && !pause_in) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
`ifdef FIB_CTRL_TIMEOUT_EN
                wd_clr = 1'b0;
                wd_en  = !pause_in;
`endif
                if (fib_done) begin
                    rsp_f_d = fib_f;
                    rsp_n_d = n_q;
`ifdef FIB_CTRL_TIMEOUT_EN
                    rsp_err_d = 1'b0;
`endif
                    state_d = RESP;
                end
`ifdef FIB_CTRL_TIMEOUT_EN
                else if (wd_expire) begin
                    rsp_f_d   = '0;
                    rsp_n_d   = n_q;
                    rsp_err_d = 1'b1;
                    state_d   = RESP;
                end
`endif
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            n_q     <= '0;
            rsp_f_q <= '0;
            rsp_n_q <= '0;
`ifdef FIB_CTRL_TIMEOUT_EN
            rsp_err_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            rsp_f_q <= rsp_f_d;
            rsp_n_q <= rsp_n_d;
`ifdef FIB_CTRL_TIMEOUT_EN
            rsp_err_q <= rsp_err_d;
`endif
        end
    end

    assign fib_pause = pause_in;
    assign fib_n     = n_q;
    assign rsp_f     = rsp_f_q;
    assign rsp_n     = rsp_n_q;
    assign state_dbg = state_q;
`ifdef FIB_CTRL_TIMEOUT_EN
    assign rsp_err   = rsp_err_q;
`else
    assign rsp_err   = 1'b0;
`endif

`ifdef FORMAL
    always @(posedge clk) begin
        if (!rst && !$past(rst)) begin
            if ($past(rsp_valid && !rsp_ready)) begin
                assert (rsp_f == $past(rsp_f) && rsp_n == $past(rsp_n) && rsp_err == $past(rsp_err));
            end
            if ($past(fib_busy) && fib_busy && $past(state_q) != IDLE) begin
                assert (fib_n == $past(fib_n));
            end
        end
        assert (!(fib_start && fib_busy));
        assert (!req_ready || state_q == IDLE);
    end
`endif

endmodule

// File: doc/fib_ctrl.md
FIB_CTRL -- requirements
Module: fib_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 32: unpaused WAIT cycles before a request is aborted (used only when FIB_CTRL_TIMEOUT_EN is defined).
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 rst  in  1  reset; synchronous, active-high.
REQ-004 req_valid  in  1 / req_ready  out  1 / req_n  in  4: request handshake; transfer when both valid and ready are high.
REQ-005 rsp_valid  out  1 / rsp_ready  in  1 / rsp_f  out  10 / rsp_n  out  4 / rsp_err  out  1: response handshake.
REQ-006 pause_in  in  1: external stall, forwarded unchanged to fib_pause.
REQ-007 fib_start  out  1 / fib_pause  out  1 / fib_n  out  4: drive the downstream Fibonacci engine.
REQ-008 fib_busy  in  1 / fib_done  in  1 / fib_f  in  10: status and result from the engine.

Function
REQ-009 FSM states: IDLE, ISSUE, WAIT, RESP.
REQ-010 IDLE: req_ready=1; on transfer, register req_n into n_q and go to ISSUE; req_ready=0 in all other states.
REQ-011 fib_n=n_q at all times; n_q changes only on a request transfer (stable while engine busy).
REQ-012 ISSUE: fib_start = !fib_busy; leave for WAIT on the first cycle with fib_start=1 and pause_in=0; otherwise hold in ISSUE.
REQ-013 WAIT: on fib_done=1 capture rsp_f<=fib_f, rsp_n<=n_q, rsp_err<=0, go to RESP.
REQ-014 RESP: rsp_valid=1, rsp_f/rsp_n/rsp_err stable until rsp_ready=1; on handshake go to IDLE; no new request is accepted in the same cycle.
REQ-015 Latency: engine start accepted in cycle t -> fib_done at t+n+2 (unpaused) -> rsp_valid at t+n+3; each pause_in cycle adds one.
REQ-016 fib_done observed in IDLE, ISSUE or RESP is ignored (stale completion).
REQ-017 Expected results: rsp_f = F(n+1): n=0->1, 1->1, 2->2, 3->3, 4->5, 5->8, 6->13, 15->987; no width overflow for 10-bit rsp_f.
REQ-018 Simultaneous fib_done and pause_in in WAIT: done wins; result captured.

Reset
REQ-019 rst=1 forces IDLE; rsp_valid=0, rsp_err=0, rsp_f=0, rsp_n=0, n_q=0, fib_start=0, timeout counter=0.
REQ-020 Reset mid-operation discards the in-flight request; the engine has no reset, so the following ISSUE waits for fib_busy=0 per REQ-012.

Configuration
REQ-021 Macro FIB_CTRL_TIMEOUT_EN defined: WAIT counts cycles with pause_in=0; when count reaches TIMEOUT without fib_done, go to RESP with rsp_err=1, rsp_f=0, rsp_n=n_q.
REQ-022 Macro FIB_CTRL_TIMEOUT_EN undefined: no counter logic; WAIT exits only on fib_done; rsp_err tied 0.

Structure
REQ-023 Shared package fib_pkg: N_W=4, F_W=10, state enum typedef (IDLE/ISSUE/WAIT/RESP).
REQ-024 One sub-module, fib_ctrl_wdog (timeout counter with clear/enable/expire), instantiated only under FIB_CTRL_TIMEOUT_EN.
REQ-025 Formal properties guarded by FORMAL: rsp payload stable while rsp_valid && !rsp_ready; fib_n stable while fib_busy; fib_start never asserted while fib_busy; req_ready only in IDLE.

Verification
REQ-026 req_n=5, rsp_ready=1, pause_in=0 -> rsp_f=8, rsp_n=5, rsp_err=0, rsp_valid 8 cycles after the start cycle.
REQ-027 Sweep req_n=0..15 back-to-back -> rsp_f = 1,1,2,3,5,8,13,21,34,55,89,144,233,377,610,987.
REQ-028 req_n=3, rsp_ready low 4 cycles after rsp_valid -> rsp_f=3 held stable, req_ready=0 until handshake.
REQ-029 req_n=4, pause_in high 3 cycles during WAIT -> rsp_f=5, response 3 cycles later than unpaused.
REQ-030 FIB_CTRL_TIMEOUT_EN, TIMEOUT=32, fib_done tied 0 -> rsp_valid with rsp_err=1, rsp_f=0 after 32 WAIT cycles.
REQ-031 rst pulsed in WAIT with req_n=9 -> rsp_valid=0 next cycle; next request n=2 starts only after fib_busy=0 and returns rsp_f=2.
